// File: rtl/key_entry_if.sv
// Keypad entry bus: key strobes and second tick in, entry buffer and
// load/error strobes out.
interface key_entry_if;
    logic       one_second;
    logic [3:0] key;
    logic       key_down;
    logic [3:0] key_buffer_ms_hr;
    logic [3:0] key_buffer_ls_hr;
    logic [3:0] key_buffer_ms_min;
    logic [3:0] key_buffer_ls_min;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       entry_error;
    logic       entry_active;

    modport master (
        output one_second, key, key_down,
        input  key_buffer_ms_hr, key_buffer_ls_hr,
        input  key_buffer_ms_min, key_buffer_ls_min,
        input  load_new_alarm, load_new_time,
        input  entry_error, entry_active
    );

    modport slave (
        input  one_second, key, key_down,
        output key_buffer_ms_hr, key_buffer_ls_hr,
        output key_buffer_ms_min, key_buffer_ls_min,
        output load_new_alarm, load_new_time,
        output entry_error, entry_active
    );
endinterface

// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: collects HH:MM digits, validates them and
// strobes the alarm register or time counter on a command key.
module key_entry_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic        clock,
    input  logic        reset,
    key_entry_if.slave  kif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [8:0] TMO       = 9'(TIMEOUT_S);

    state_t     state;
    logic [2:0] count;
    logic [7:0] timer;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       ld_alarm, ld_time, err, active;

    logic is_digit;
    logic is_cmd;
    logic valid_time;
    logic tmo_hit;

    always_comb begin
        is_digit   = (kif.key <= 4'd9);
        is_cmd     = (kif.key == KEY_ALARM) || (kif.key == KEY_TIME);
        valid_time = (ms_hr <= 4'd2) &&
                     ((ms_hr == 4'd2) ? (ls_hr <= 4'd3) : (ls_hr <= 4'd9)) &&
                     (ms_min <= 4'd5) &&
                     (ls_min <= 4'd9);
        tmo_hit    = (({1'b0, timer} + 9'd1) == TMO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 3'd0;
            timer    <= 8'd0;
            ms_hr    <= 4'd0;
            ls_hr    <= 4'd0;
            ms_min   <= 4'd0;
            ls_min   <= 4'd0;
            ld_alarm <= 1'b0;
            ld_time  <= 1'b0;
            err      <= 1'b0;
            active   <= 1'b0;
        end else begin
            ld_alarm <= 1'b0;
            ld_time  <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (kif.key_down && is_digit) begin
                        ms_hr  <= ls_hr;
                        ls_hr  <= ms_min;
                        ms_min <= ls_min;
                        ls_min <= kif.key;
                        count  <= 3'd1;
                        timer  <= 8'd0;
                        state  <= ENTRY;
                        active <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (kif.key_down && is_digit) begin
                        ms_hr  <= ls_hr;
                        ls_hr  <= ms_min;
                        ms_min <= ls_min;
                        ls_min <= kif.key;
                        count  <= (count == 3'd4) ? 3'd4 : count + 3'd1;
                        timer  <= 8'd0;
                    end else if (kif.key_down && is_cmd) begin
                        active <= 1'b0;
                        if (count == 3'd4 && valid_time) begin
                            // buffer is held through LOAD for the downstream sample
                            state    <= LOAD;
                            ld_alarm <= (kif.key == KEY_ALARM);
                            ld_time  <= (kif.key == KEY_TIME);
                        end else begin
                            state  <= IDLE;
                            err    <= 1'b1;
                            count  <= 3'd0;
                            timer  <= 8'd0;
                            ms_hr  <= 4'd0;
                            ls_hr  <= 4'd0;
                            ms_min <= 4'd0;
                            ls_min <= 4'd0;
                        end
                    end else if (!kif.key_down && kif.one_second) begin
                        if (tmo_hit) begin
                            state  <= IDLE;
                            active <= 1'b0;
                            count  <= 3'd0;
                            timer  <= 8'd0;
                            ms_hr  <= 4'd0;
                            ls_hr  <= 4'd0;
                            ms_min <= 4'd0;
                            ls_min <= 4'd0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                LOAD: begin
                    state  <= IDLE;
                    count  <= 3'd0;
                    timer  <= 8'd0;
                    ms_hr  <= 4'd0;
                    ls_hr  <= 4'd0;
                    ms_min <= 4'd0;
                    ls_min <= 4'd0;
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign kif.key_buffer_ms_hr  = ms_hr;
    assign kif.key_buffer_ls_hr  = ls_hr;
    assign kif.key_buffer_ms_min = ms_min;
    assign kif.key_buffer_ls_min = ls_min;
    assign kif.load_new_alarm    = ld_alarm;
    assign kif.load_new_time     = ld_time;
    assign kif.entry_error       = err;
    assign kif.entry_active      = active;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with TIMEOUT_S = 3.
module tb_key_entry_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    key_entry_if kif ();

    key_entry_ctrl #(.TIMEOUT_S(3)) dut (
        .clock (clock),
        .reset (reset),
        .kif   (kif.slave)
    );

    logic [15:0] bufv;
    assign bufv = {kif.key_buffer_ms_hr, kif.key_buffer_ls_hr,
                   kif.key_buffer_ms_min, kif.key_buffer_ls_min};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic press(input logic [3:0] k);
        @(negedge clock);
        kif.key      = k;
        kif.key_down = 1'b1;
        @(posedge clock);
        #1;
        kif.key_down = 1'b0;
        kif.key      = 4'd0;
    endtask

    task automatic pulse();
        @(negedge clock);
        kif.one_second = 1'b1;
        @(posedge clock);
        #1;
        kif.one_second = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        kif.key        = 4'd0;
        kif.key_down   = 1'b0;
        kif.one_second = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) step();
        checks++;
        if (bufv !== 16'h0000) begin
            errors++;
            $display("FAIL reset_buf got %h exp 0000", bufv);
        end
        checks++;
        if ({kif.load_new_alarm, kif.load_new_time,
             kif.entry_error, kif.entry_active} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000",
                     {kif.load_new_alarm, kif.load_new_time,
                      kif.entry_error, kif.entry_active});
        end
    endtask

    task automatic test_alarm_commit();
        press(4'd0); press(4'd7); press(4'd3); press(4'd0);
        checks++;
        if (bufv !== 16'h0730 || kif.entry_active !== 1'b1) begin
            errors++;
            $display("FAIL entry_0730 got %h act %b exp 0730 act 1",
                     bufv, kif.entry_active);
        end
        press(4'hA);
        checks++;
        if ({kif.load_new_alarm, kif.load_new_time} !== 2'b10 ||
            bufv !== 16'h0730) begin
            errors++;
            $display("FAIL alarm_strobe got a%b t%b buf %h exp a1 t0 0730",
                     kif.load_new_alarm, kif.load_new_time, bufv);
        end
        step();
        checks++;
        if ({kif.load_new_alarm, kif.load_new_time, kif.entry_active} !== 3'b000 ||
            bufv !== 16'h0000) begin
            errors++;
            $display("FAIL alarm_after got a%b t%b act %b buf %h exp 0 0 0 0000",
                     kif.load_new_alarm, kif.load_new_time,
                     kif.entry_active, bufv);
        end
    endtask

    task automatic test_invalid_time();
        press(4'd2); press(4'd4); press(4'd0); press(4'd0);
        press(4'hB);
        checks++;
        if ({kif.entry_error, kif.load_new_alarm, kif.load_new_time} !== 3'b100 ||
            bufv !== 16'h0000 || kif.entry_active !== 1'b0) begin
            errors++;
            $display("FAIL err_2400 got e%b a%b t%b buf %h act %b exp e1 a0 t0 0000 0",
                     kif.entry_error, kif.load_new_alarm, kif.load_new_time,
                     bufv, kif.entry_active);
        end
        step();
        checks++;
        if (kif.entry_error !== 1'b0) begin
            errors++;
            $display("FAIL err_len got %b exp 0", kif.entry_error);
        end
    endtask

    task automatic test_short_entry();
        press(4'd1); press(4'd9);
        press(4'hA);
        checks++;
        if ({kif.entry_error, kif.load_new_alarm, kif.load_new_time} !== 3'b100 ||
            bufv !== 16'h0000) begin
            errors++;
            $display("FAIL err_short got e%b a%b t%b buf %h exp e1 a0 t0 0000",
                     kif.entry_error, kif.load_new_alarm, kif.load_new_time, bufv);
        end
        step();
    endtask

    task automatic test_overflow_time();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        checks++;
        if (bufv !== 16'h2345) begin
            errors++;
            $display("FAIL shift5 got %h exp 2345", bufv);
        end
        press(4'hB);
        checks++;
        if ({kif.load_new_time, kif.load_new_alarm, kif.entry_error} !== 3'b100 ||
            bufv !== 16'h2345) begin
            errors++;
            $display("FAIL time_strobe got t%b a%b e%b buf %h exp t1 a0 e0 2345",
                     kif.load_new_time, kif.load_new_alarm, kif.entry_error, bufv);
        end
        step();
        checks++;
        if (kif.load_new_time !== 1'b0 || bufv !== 16'h0000) begin
            errors++;
            $display("FAIL time_after got t%b buf %h exp t0 0000",
                     kif.load_new_time, bufv);
        end
    endtask

    task automatic test_max_valid();
        press(4'd2); press(4'd3); press(4'd5); press(4'd9);
        press(4'hA);
        checks++;
        if ({kif.load_new_alarm, kif.entry_error} !== 2'b10 ||
            bufv !== 16'h2359) begin
            errors++;
            $display("FAIL alarm_2359 got a%b e%b buf %h exp a1 e0 2359",
                     kif.load_new_alarm, kif.entry_error, bufv);
        end
        step();
    endtask

    task automatic test_timeout();
        press(4'd1);
        pulse(); pulse();
        checks++;
        if (kif.entry_active !== 1'b1 || bufv !== 16'h0001) begin
            errors++;
            $display("FAIL tmo_pre got act %b buf %h exp 1 0001",
                     kif.entry_active, bufv);
        end
        pulse();
        checks++;
        if (kif.entry_active !== 1'b0 || bufv !== 16'h0000 ||
            {kif.load_new_alarm, kif.load_new_time, kif.entry_error} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_fire got act %b buf %h strobes %b exp 0 0000 000",
                     kif.entry_active, bufv,
                     {kif.load_new_alarm, kif.load_new_time, kif.entry_error});
        end
    endtask

    task automatic test_tick_collision();
        press(4'd1);
        pulse();
        @(negedge clock);
        kif.key        = 4'd2;
        kif.key_down   = 1'b1;
        kif.one_second = 1'b1;
        @(posedge clock);
        #1;
        kif.key_down   = 1'b0;
        kif.one_second = 1'b0;
        kif.key        = 4'd0;
        pulse(); pulse();
        checks++;
        if (kif.entry_active !== 1'b1 || bufv !== 16'h0012) begin
            errors++;
            $display("FAIL tick_collide got act %b buf %h exp 1 0012",
                     kif.entry_active, bufv);
        end
        pulse();
        checks++;
        if (kif.entry_active !== 1'b0 || bufv !== 16'h0000) begin
            errors++;
            $display("FAIL tick_collide_tmo got act %b buf %h exp 0 0000",
                     kif.entry_active, bufv);
        end
    endtask

    task automatic test_ignored_key();
        press(4'd6);
        pulse(); pulse();
        press(4'hC);
        checks++;
        if (kif.entry_active !== 1'b1 || bufv !== 16'h0006) begin
            errors++;
            $display("FAIL ignored_key got act %b buf %h exp 1 0006",
                     kif.entry_active, bufv);
        end
        pulse();
        checks++;
        if (kif.entry_active !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_restart got act %b exp 0",
                     kif.entry_active);
        end
    endtask

    task automatic test_async_reset();
        press(4'd1); press(4'd2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (kif.entry_active !== 1'b0 || bufv !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst_entry got act %b buf %h exp 0 0000",
                     kif.entry_active, bufv);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        press(4'hA);
        checks++;
        if ({kif.load_new_alarm, kif.load_new_time, kif.entry_error} !== 3'b000) begin
            errors++;
            $display("FAIL rst_cmd_alone got %b exp 000",
                     {kif.load_new_alarm, kif.load_new_time, kif.entry_error});
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(4'hB);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (kif.load_new_time !== 1'b0 || bufv !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst_load got t%b buf %h exp t0 0000",
                     kif.load_new_time, bufv);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++;
        if ({kif.load_new_alarm, kif.load_new_time, kif.entry_error} !== 3'b000) begin
            errors++;
            $display("FAIL post_rst_strobe got %b exp 000",
                     {kif.load_new_alarm, kif.load_new_time, kif.entry_error});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alarm_commit();
        test_invalid_time();
        test_short_entry();
        test_overflow_time();
        test_max_valid();
        test_timeout();
        test_tick_collision();
        test_ignored_key();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Keypad entry controller that sits directly upstream of the alarm register and the time counter. It collects decimal key presses into a 4-digit HH:MM buffer and validates the entered time. On an ALARM or TIME command key it issues a one-cycle load strobe, during which the buffer digits drive the downstream `new_alarm_*` / `new_current_time_*` inputs. Incomplete entries are discarded after a configurable idle timeout.

## Interface
- `TIMEOUT_S`, default 10: idle seconds before an entry is abandoned; legal range 1–255.
- `clock`  input  1  system clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state and outputs
- `one_second`  input  1  one-cycle pulse per second from the timebase
- `key`  input  4  key code: 0–9 digit, 4'hA ALARM, 4'hB TIME, 4'hC–4'hF ignored
- `key_down`  input  1  one-cycle strobe; `key` is valid only when high
- `key_buffer_ms_hr`, `key_buffer_ls_hr`, `key_buffer_ms_min`, `key_buffer_ls_min`  output  4 each  registered entry digits (BCD)
- `load_new_alarm`  output  1  one-cycle strobe, alarm register samples buffer
- `load_new_time`  output  1  one-cycle strobe, time counter samples buffer
- `entry_error`  output  1  one-cycle strobe, commit rejected
- `entry_active`  output  1  high while in ENTRY

## Operation
- Reset: all buffer digits 0, all strobes 0, `entry_active` 0, digit count 0, timer 0, state IDLE.
- State IDLE:
  - digit key → shift in, count=1, timer=0, go to ENTRY.
  - ALARM/TIME/ignored keys → no effect, no strobe.
- State ENTRY:
  - Digit key → shift left: ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←key. Count saturates at 4 (a fifth digit drops the oldest). Timer=0.
  - ALARM/TIME key with count==4 and valid time → go to LOAD; assert the matching strobe.
  - ALARM/TIME key with count<4 or invalid time → `entry_error`, clear buffer/count/timer, go to IDLE.
  - Ignored codes (C–F): no effect, timer not reset.
  - `one_second` with no `key_down` → timer+1. When the timer would reach `TIMEOUT_S` → clear buffer/count/timer, go to IDLE. No strobe on timeout.
- State LOAD (exactly one cycle): buffer held stable while the strobe is high. Next edge: strobe low, buffer/count/timer cleared, go to IDLE. Any `key_down` in LOAD is dropped.
- Valid time:
  - ms_hr ≤ 2
  - ls_hr ≤ 9, and ls_hr ≤ 3 when ms_hr == 2
  - ms_min ≤ 5
  - ls_min ≤ 9
  - Only digits enter the buffer, so every digit is always 0–9.
- `load_new_alarm` and `load_new_time` are never high together. At most one of the three strobes is high in any cycle.
- `entry_active` = (state == ENTRY), registered.

## Timing
- `key_down` sampled at edge N; buffer/state change visible after edge N (latency 1).
- Commit key at edge N:
  - Strobe high from edge N to edge N+1; buffer holds the entered value during that cycle.
  - Buffer reads 0 after edge N+1.
- Error key at edge N: `entry_error` high for cycle N→N+1; buffer already 0 in that cycle.
- `key_down` and `one_second` in the same cycle: the key is processed, timer=0, the tick is ignored.
- Timeout: with the last key at edge K, the buffer clears at the edge sampling the `TIMEOUT_S`-th subsequent `one_second` pulse.
- Async reset mid-entry or mid-LOAD: outputs go to reset values immediately. A strobe in progress is cut short. No strobe after reset deassertion until a new full entry.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then idle 20 cycles → all buffer digits 0; `load_new_alarm`, `load_new_time`, `entry_error`, `entry_active` all 0.
- Keys 0,7,3,0 then ALARM → buffer 0,7,3,0 with `load_new_alarm` high for exactly 1 cycle, `load_new_time` 0 throughout; buffer 0 and `entry_active` 0 the next cycle.
- Keys 2,4,0,0 then TIME → `entry_error` 1 cycle, no load strobe, buffer 0. Repeat with 1,9 then ALARM (count 2) → `entry_error`.
- Keys 1,2,3,4,5 then TIME → buffer 2,3,4,5 and `load_new_time` 1 cycle. Keys 2,3,5,9 then ALARM → accepted.
- `TIMEOUT_S`=3: key 1, then three `one_second` pulses → buffer 0 and `entry_active` 0 after the third pulse. Key + `one_second` in the same cycle at pulse 2 → timer restarts; the entry survives two more pulses.
- Keys 1,2 then assert `reset` asynchronously mid-cycle → outputs 0 immediately. After release, ALARM alone → no strobe, no error.
